dds_sequencer: RTL and testbench

DDS_SEQUENCER -- requirements
Module: dds_sequencer

---
 rtl/dds_sequencer_pkg.sv | 40 ++++
 rtl/dds_dwell_counter.sv | 47 ++++
 rtl/dds_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_dds_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sequencer_pkg.sv
// Shared configuration for the DDS command sequencer: widths, opcodes,
// shape codes, FSM state encoding and the shadow/active config payload.
package dds_sequencer_pkg;

  localparam int unsigned ROM_PHASE_BIT = 17;
  localparam int unsigned DAC_MAX_V_BIT = 13;

  localparam int unsigned PHASE_W = ROM_PHASE_BIT - 1;
  localparam int unsigned AMP_W   = DAC_MAX_V_BIT - 1;
  localparam int unsigned CMD_W   = (PHASE_W > AMP_W) ? PHASE_W : AMP_W;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned SHAPE_W = 2;
  localparam int unsigned OP_W    = 2;

  // Command opcodes
  localparam logic [OP_W-1:0] OP_SET_FREQ  = 2'd0;
  localparam logic [OP_W-1:0] OP_SET_AMP   = 2'd1;
  localparam logic [OP_W-1:0] OP_SET_SHAPE = 2'd2;
  localparam logic [OP_W-1:0] OP_SWEEP     = 2'd3;

  // Waveform shape codes; SHAPE_INVALID is never accepted
  localparam logic [SHAPE_W-1:0] SHAPE_SINE     = 2'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_TRIANGLE = 2'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_SQUARE   = 2'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_INVALID  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWEEP   = 2'd2
  } dds_state_e;

  // Frequency / amplitude / shape triple, used for both shadow and active sets
  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic [AMP_W-1:0]   amp;
    logic [SHAPE_W-1:0] shape;
  } dds_cfg_t;

endpackage

// File: rtl/dds_dwell_counter.sv
// Counts phase wraps during a sweep step and flags the wrap that completes
// the programmed dwell (a dwell of 0 behaves as 1).
//   clk, rst      : clock, synchronous active-high reset
//   clear         : restart the count (sweep start / abort)
//   inc           : one phase wrap observed while sweeping
//   dwell         : wraps per sweep step
//   expire_c      : combinational, high on the wrap that ends the dwell
module dds_dwell_counter
  import dds_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire_c
);

  localparam int unsigned CW = DWELL_W + 1;

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic               at_term;

  // Terminal count: compare widened so count+1 cannot wrap past 255
  always_comb begin
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    at_term   = (CW'(count_q) + CW'(1)) >= CW'(dwell_eff);
    expire_c  = inc && at_term;
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_term ? '0 : count_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dds_sequencer.sv
// DDS command sequencer: buffers frequency/amplitude/shape commands in shadow
// registers and applies them glitch-free on the next phase wrap; also runs a
// saturating linear frequency sweep stepped every N phase wraps.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake and payload
//   sweep_step, sweep_dwell             : sweep increment and wraps per step
//   phase_wrap                          : accumulator wrap pulse
//   phase_M, signal_A, signal_shape     : active configuration (registered)
//   busy, sweep_done, cmd_err           : status (registered)
module dds_sequencer
  import dds_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [CMD_W-1:0]   cmd_data,
  input  logic [PHASE_W-1:0] sweep_step,
  input  logic [DWELL_W-1:0] sweep_dwell,
  input  logic               phase_wrap,
  output logic [PHASE_W-1:0] phase_M,
  output logic [AMP_W-1:0]   signal_A,
  output logic [SHAPE_W-1:0] signal_shape,
  output logic               busy,
  output logic               sweep_done,
  output logic               cmd_err
);

  localparam int unsigned SUM_W = PHASE_W + 1;

  dds_state_e         state_q, state_d;
  dds_cfg_t           shadow_q, shadow_d;
  dds_cfg_t           active_q, active_d;
  logic [PHASE_W-1:0] sweep_stop_q, sweep_stop_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic               cmd_err_q, cmd_err_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic               cmd_fire;
  logic               is_set;
  logic               bad_shape;
  logic               set_ok;
  logic               sweep_req;
  logic               sweep_ok;
  logic               apply_now;
  logic               dwell_clear;
  logic               dwell_inc;
  logic               dwell_expire_c;
  logic               step_now;
  logic               sweep_hit;
  logic [SUM_W-1:0]   sweep_sum;
  logic [PHASE_W-1:0] sweep_next;
  dds_cfg_t           merged;

  // Command decode and sweep arithmetic shared by next-state and output logic
  always_comb begin
    cmd_fire  = cmd_valid && cmd_ready_q;
    is_set    = (cmd_op != OP_SWEEP);
    bad_shape = (cmd_op == OP_SET_SHAPE) && (cmd_data[SHAPE_W-1:0] == SHAPE_INVALID);
    set_ok    = cmd_fire && is_set && !bad_shape;
    sweep_req = cmd_fire && !is_set;
    sweep_ok  = sweep_req && (state_q == ST_IDLE) && (cmd_data > CMD_W'(phase_m_ext()));
    apply_now = (state_q == ST_PENDING) && phase_wrap;

    // Shadow with this cycle's accepted SET_* folded in
    merged = shadow_q;
    if (set_ok) begin
      case (cmd_op)
        OP_SET_FREQ:  merged.phase = PHASE_W'(cmd_data);
        OP_SET_AMP:   merged.amp   = AMP_W'(cmd_data);
        default:      merged.shape = cmd_data[SHAPE_W-1:0];
      endcase
    end

    // Widened add so an overflowing step saturates at the stop value
    sweep_sum  = SUM_W'(active_q.phase) + SUM_W'(sweep_step);
    sweep_hit  = (sweep_step == '0) || (sweep_sum >= SUM_W'(sweep_stop_q));
    sweep_next = sweep_hit ? sweep_stop_q : PHASE_W'(sweep_sum);

    dwell_inc   = (state_q == ST_SWEEP) && phase_wrap;
    dwell_clear = sweep_ok || ((state_q == ST_SWEEP) && set_ok);
    // A SET_* abort takes priority over a coincident sweep step
    step_now    = (state_q == ST_SWEEP) && dwell_expire_c && !set_ok;
  end

  function automatic logic [PHASE_W-1:0] phase_m_ext();
    return active_q.phase;
  endfunction

  dds_dwell_counter u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clear    (dwell_clear),
    .inc      (dwell_inc),
    .dwell    (sweep_dwell),
    .expire_c (dwell_expire_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (set_ok) begin
          state_d = ST_PENDING;
        end else if (sweep_ok) begin
          state_d = ST_SWEEP;
        end
      end
      ST_PENDING: begin
        if (apply_now) begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (set_ok) begin
          state_d = ST_PENDING;
        end else if (step_now && sweep_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    shadow_d     = merged;
    active_d     = active_q;
    sweep_stop_d = sweep_stop_q;
    sweep_done_d = 1'b0;
    cmd_err_d    = (sweep_req && !sweep_ok) || (cmd_fire && is_set && bad_shape);
    cmd_ready_d  = 1'b1;
    busy_d       = (state_d != ST_IDLE);

    if (apply_now) begin
      active_d = merged;
    end
    if (sweep_ok) begin
      sweep_stop_d = PHASE_W'(cmd_data);
    end
    if (step_now) begin
      active_d.phase = sweep_next;
      sweep_done_d   = sweep_hit;
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      sweep_stop_q <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      sweep_stop_q <= sweep_stop_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      cmd_err_q    <= cmd_err_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign phase_M      = active_q.phase;
  assign signal_A     = active_q.amp;
  assign signal_shape = active_q.shape;
  assign busy         = busy_q;
  assign sweep_done   = sweep_done_q;
  assign cmd_err      = cmd_err_q;
  assign cmd_ready    = cmd_ready_q;

endmodule

// File: tb/tb_dds_sequencer.sv
// Directed bench for dds_sequencer: stimulus pushes hand-computed output
// snapshots tagged with the cycle they must appear in; a monitor pops and
// compares them, and tallies sweep_done / cmd_err pulses.
module tb_dds_sequencer;
  import dds_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [OP_W-1:0]    cmd_op;
  logic [CMD_W-1:0]   cmd_data;
  logic [PHASE_W-1:0] sweep_step;
  logic [DWELL_W-1:0] sweep_dwell;
  logic               phase_wrap;
  logic [PHASE_W-1:0] phase_M;
  logic [AMP_W-1:0]   signal_A;
  logic [SHAPE_W-1:0] signal_shape;
  logic               busy;
  logic               sweep_done;
  logic               cmd_err;

  dds_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .sweep_step   (sweep_step),
    .sweep_dwell  (sweep_dwell),
    .phase_wrap   (phase_wrap),
    .phase_M      (phase_M),
    .signal_A     (signal_A),
    .signal_shape (signal_shape),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    string              name;
    logic [PHASE_W-1:0] ph;
    logic [AMP_W-1:0]   amp;
    logic [SHAPE_W-1:0] sh;
    logic               bsy;
    logic               dn;
    logic               er;
    logic               rdy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   done_seen = 0;
  int   err_seen = 0;
  bit   stim_done = 1'b0;
  int   drain = 0;

  localparam int EXP_DONE = 3;
  localparam int EXP_ERR  = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [OP_W-1:0] op,
                       input logic [CMD_W-1:0] d, input logic w);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_data   = d;
    phase_wrap = w;
    tick();
    cmd_valid  = 1'b0;
    phase_wrap = 1'b0;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [CMD_W-1:0] d);
    drive(1'b1, op, d, 1'b0);
  endtask

  task automatic wrap();
    drive(1'b0, OP_SET_FREQ, '0, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, OP_SET_FREQ, '0, 1'b0);
  endtask

  // Expected snapshot for the cycle just entered
  task automatic expect_now(input string nm, input logic [PHASE_W-1:0] ph,
                            input logic [AMP_W-1:0] a, input logic [SHAPE_W-1:0] s,
                            input logic b, input logic d, input logic e,
                            input logic r = 1'b1);
    exp_t x;
    x.cyc = cyc; x.name = nm; x.ph = ph; x.amp = a; x.sh = s;
    x.bsy = b; x.dn = d; x.er = e; x.rdy = r;
    sb.push_back(x);
  endtask

  // Monitor: compare due snapshots, tally pulses, finish the run
  always @(negedge clk) begin
    exp_t x;
    if (rst === 1'b0) begin
      if (sweep_done === 1'b1) done_seen++;
      if (cmd_err === 1'b1) err_seen++;
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      n_total++;
      if (x.cyc != cyc) begin
        $display("FAIL %s: snapshot for cycle %0d reached monitor at cycle %0d", x.name, x.cyc, cyc);
      end else if (phase_M !== x.ph || signal_A !== x.amp || signal_shape !== x.sh ||
                   busy !== x.bsy || sweep_done !== x.dn || cmd_err !== x.er ||
                   cmd_ready !== x.rdy) begin
        $display("FAIL %s @%0d: got ph=%0d amp=%0d sh=%0d busy=%b done=%b err=%b rdy=%b, want ph=%0d amp=%0d sh=%0d busy=%b done=%b err=%b rdy=%b",
                 x.name, cyc, phase_M, signal_A, signal_shape, busy, sweep_done, cmd_err, cmd_ready,
                 x.ph, x.amp, x.sh, x.bsy, x.dn, x.er, x.rdy);
      end else begin
        n_pass++;
      end
    end
    if (stim_done) drain++;
    if (cyc > 5000 || (stim_done && (sb.size() == 0 || drain > 20))) begin
      n_total++;
      if (sb.size() != 0 || cyc > 5000)
        $display("FAIL drain: %0d snapshots still queued at cycle %0d, want 0", sb.size(), cyc);
      else
        n_pass++;
      n_total++;
      if (done_seen != EXP_DONE)
        $display("FAIL done_pulses: got %0d, want %0d", done_seen, EXP_DONE);
      else
        n_pass++;
      n_total++;
      if (err_seen != EXP_ERR)
        $display("FAIL err_pulses: got %0d, want %0d", err_seen, EXP_ERR);
      else
        n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    sweep_step = '0; sweep_dwell = '0; phase_wrap = 1'b0;
    tick(); tick(); tick();
    expect_now("reset", 0, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    tick();
    expect_now("reset_release", 0, 0, 0, 0, 0, 0);

    // Deferred frequency update lands one cycle after the wrap
    issue(OP_SET_FREQ, 16'd10);
    expect_now("freq_pending", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      expect_now("freq_hold", 0, 0, 0, 1, 0, 0);
    end
    wrap();
    expect_now("freq_apply", 10, 0, 0, 0, 0, 0);

    // Coalesced amplitude + shape applied together
    issue(OP_SET_AMP, 16'd1200);
    expect_now("amp_pending", 10, 0, 0, 1, 0, 0);
    issue(OP_SET_SHAPE, 16'd1);
    expect_now("shape_pending", 10, 0, 0, 1, 0, 0);
    wrap();
    expect_now("amp_shape_apply", 10, 1200, 1, 0, 0, 0);

    // Rejected commands
    issue(OP_SET_SHAPE, 16'd3);
    expect_now("bad_shape", 10, 1200, 1, 0, 0, 1);
    issue(OP_SWEEP, 16'd5);
    expect_now("sweep_below", 10, 1200, 1, 0, 0, 1);
    idle();
    expect_now("err_single", 10, 1200, 1, 0, 0, 0);

    // Sweep 10 -> 20 by 4, dwell 2
    sweep_step = 16'd4; sweep_dwell = 8'd2;
    issue(OP_SWEEP, 16'd20);
    expect_now("sweep_start", 10, 1200, 1, 1, 0, 0);
    wrap(); expect_now("sweep_w1", 10, 1200, 1, 1, 0, 0);
    wrap(); expect_now("sweep_14", 14, 1200, 1, 1, 0, 0);
    wrap(); expect_now("sweep_w3", 14, 1200, 1, 1, 0, 0);
    wrap(); expect_now("sweep_18", 18, 1200, 1, 1, 0, 0);
    wrap(); expect_now("sweep_w5", 18, 1200, 1, 1, 0, 0);
    wrap(); expect_now("sweep_20_sat", 20, 1200, 1, 0, 1, 0);
    idle(); expect_now("sweep_done_clr", 20, 1200, 1, 0, 0, 0);

    // Abort a sweep with SET_FREQ at phase 14
    issue(OP_SET_FREQ, 16'd10);
    wrap(); expect_now("freq_10", 10, 1200, 1, 0, 0, 0);
    issue(OP_SWEEP, 16'd30);
    expect_now("sweep2_start", 10, 1200, 1, 1, 0, 0);
    wrap(); wrap(); expect_now("sweep2_14", 14, 1200, 1, 1, 0, 0);
    issue(OP_SET_FREQ, 16'd7);
    expect_now("abort_hold", 14, 1200, 1, 1, 0, 0);
    idle(); idle(); expect_now("abort_no_step", 14, 1200, 1, 1, 0, 0);
    wrap(); expect_now("abort_apply", 7, 1200, 1, 0, 0, 0);

    // Zero step and zero dwell: jump to stop on first wrap
    sweep_step = '0; sweep_dwell = '0;
    issue(OP_SWEEP, 16'd100);
    wrap(); expect_now("step0_stop", 100, 1200, 1, 0, 1, 0);

    // Overflowing step saturates at stop
    sweep_step = 16'hFFF0; sweep_dwell = 8'd1;
    issue(OP_SWEEP, 16'hFFFF);
    wrap(); expect_now("ovf_sat", 16'hFFFF, 1200, 1, 0, 1, 0);

    // SWEEP rejected in PENDING; SET_* coincident with wrap merges
    issue(OP_SET_AMP, 16'd5);
    expect_now("amp5_pending", 16'hFFFF, 1200, 1, 1, 0, 0);
    issue(OP_SWEEP, 16'hFFFF);
    expect_now("sweep_in_pending", 16'hFFFF, 1200, 1, 1, 0, 1);
    drive(1'b1, OP_SET_FREQ, 16'h55, 1'b1);
    expect_now("merge_on_wrap", 16'h55, 5, 1, 0, 0, 0);

    // Reset discards a pending update
    issue(OP_SET_FREQ, 16'd50);
    expect_now("pend50", 16'h55, 5, 1, 1, 0, 0);
    rst = 1'b1;
    tick();
    expect_now("mid_reset", 0, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    tick();
    wrap(); expect_now("post_reset_w1", 0, 0, 0, 0, 0, 0);
    wrap(); expect_now("post_reset_w2", 0, 0, 0, 0, 0, 0);
    idle();
    stim_done = 1'b1;
  end

endmodule
